// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states,
// operation codes and Hi/Lo source-select constants.
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_EXC   = 3'd4
  } state_t;

  localparam logic OP_MULT  = 1'b0;
  localparam logic OP_DIV   = 1'b1;

  localparam logic SEL_DIV  = 1'b0;
  localparam logic SEL_MULT = 1'b1;

  localparam int CNT_W = 6;

endpackage

// File: rtl/muldiv_cnt.sv
// Engine-latency down-counter: loaded on entry to RUN, decremented while
// running, saturating at zero so it never wraps.
module muldiv_cnt
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Control FSM that starts the mult or div engine, waits out its latency,
// loads Hi/Lo and reports completion, divide-by-zero or abort.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] operand_b,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        eng_start,
  output logic        eng_sel,
  output logic        HiLo_load,
  output logic        sel_mux_hi,
  output logic        sel_mux_lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state, next_state;
  logic             op_q;
  logic             run_first;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic             accept;

  // Abort takes priority over a start presented in the same IDLE cycle.
  assign accept = (state == ST_IDLE) && start && !abort;

  assign cnt_load_val = (op == OP_DIV) ? DIV_LOAD : MULT_LOAD;

  muldiv_cnt u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec_en   (state == ST_RUN),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      op_q      <= OP_MULT;
      run_first <= 1'b0;
    end else begin
      state     <= next_state;
      run_first <= cnt_load;
      if (accept) begin
        op_q <= op;
      end
    end
  end

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    busy       = (state != ST_IDLE);
    eng_start  = 1'b0;
    HiLo_load  = 1'b0;
    done       = 1'b0;
    div_zero   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if ((op == OP_DIV) && (operand_b == 32'd0)) begin
            next_state = ST_EXC;
          end else begin
            next_state = ST_RUN;
            cnt_load   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        eng_start = run_first;
        if (abort) begin
          next_state = ST_IDLE;
        end else if (cnt_zero) begin
          next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        HiLo_load  = !abort;
        next_state = abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        done       = !abort;
        next_state = ST_IDLE;
      end
      ST_EXC: begin
        div_zero   = !abort;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign eng_sel    = op_q;
  assign sel_mux_hi = (op_q == OP_DIV) ? SEL_DIV : SEL_MULT;
  assign sel_mux_lo = (op_q == OP_DIV) ? SEL_DIV : SEL_MULT;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with 32-cycle engines: a table of
// single-operation timelines plus hand-written restart and reset sequences.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] operand_b;
  logic        abort;
  logic        busy, done, div_zero, eng_start, eng_sel, HiLo_load;
  logic        sel_mux_hi, sel_mux_lo;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int WIN = 40;

  muldiv_sequencer #(.MULT_CYCLES(32), .DIV_CYCLES(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .operand_b  (operand_b),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .eng_start  (eng_start),
    .eng_sel    (eng_sel),
    .HiLo_load  (HiLo_load),
    .sel_mux_hi (sel_mux_hi),
    .sel_mux_lo (sel_mux_lo)
  );

  always #5 clk = ~clk;

  // Cycle numbers count edges after the one that samples start; 0 = never.
  typedef struct {
    logic        op;
    logic [31:0] b;
    int          abort_cyc;
    int          start2_cyc;
    logic        op2;
    int          es_cyc, es_cnt;
    int          hl_cyc, hl_cnt;
    int          dn_cyc, dn_cnt;
    int          dz_cyc, dz_cnt;
    int          busy_cnt, busy_last;
    logic        eng_sel;
    logic        sel;
  } vec_t;

  int es_cyc, es_cnt, hl_cyc, hl_cnt, dn_cyc, dn_cnt, dz_cyc, dz_cnt;
  int busy_cnt, busy_last, excl;
  logic sel1, hi1, lo1, sel_last;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic o, input logic [31:0] b, input int ab,
                              input int s2, input int es, input int hl,
                              input int dn, input int dz, input int bc,
                              input logic es_sel);
    vec_t v;
    v.op = o; v.b = b; v.abort_cyc = ab; v.start2_cyc = s2; v.op2 = 1'b1;
    v.es_cyc = es; v.es_cnt = (es != 0) ? 1 : 0;
    v.hl_cyc = hl; v.hl_cnt = (hl != 0) ? 1 : 0;
    v.dn_cyc = dn; v.dn_cnt = (dn != 0) ? 1 : 0;
    v.dz_cyc = dz; v.dz_cnt = (dz != 0) ? 1 : 0;
    v.busy_cnt = bc; v.busy_last = bc;
    v.eng_sel = es_sel; v.sel = ~es_sel;
    return v;
  endfunction

  task automatic sampleCycle(input int k);
    if (eng_start) begin es_cnt++; if (es_cyc == 0) es_cyc = k; end
    if (HiLo_load) begin hl_cnt++; if (hl_cyc == 0) hl_cyc = k; end
    if (done)      begin dn_cnt++; if (dn_cyc == 0) dn_cyc = k; end
    if (div_zero)  begin dz_cnt++; if (dz_cyc == 0) dz_cyc = k; end
    if (busy) begin busy_cnt++; busy_last = k; sel_last = eng_sel; end
    if ((32'(eng_start) + 32'(HiLo_load) + 32'(done) + 32'(div_zero)) > 1) excl++;
    if (k == 1) begin sel1 = eng_sel; hi1 = sel_mux_hi; lo1 = sel_mux_lo; end
  endtask

  // Called #1 after a rising edge with the sequencer idle.
  task automatic applyStimulus(input vec_t v, input int idx);
    string t;
    es_cyc = 0; es_cnt = 0; hl_cyc = 0; hl_cnt = 0; dn_cyc = 0; dn_cnt = 0;
    dz_cyc = 0; dz_cnt = 0; busy_cnt = 0; busy_last = 0; excl = 0;
    sel1 = 1'b0; hi1 = 1'b0; lo1 = 1'b0; sel_last = v.eng_sel;
    op = v.op; operand_b = v.b; start = 1'b1; abort = (v.abort_cyc == 0);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int k = 1; k <= WIN; k++) begin
      start = (k == v.start2_cyc);
      if (start) op = v.op2;
      abort = (k == v.abort_cyc);
      #1;
      sampleCycle(k);
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0;
    t = $sformatf("v%0d", idx);
    checkOutput({t, " eng_start cycle"}, es_cyc, v.es_cyc);
    checkOutput({t, " eng_start count"}, es_cnt, v.es_cnt);
    checkOutput({t, " HiLo_load cycle"}, hl_cyc, v.hl_cyc);
    checkOutput({t, " HiLo_load count"}, hl_cnt, v.hl_cnt);
    checkOutput({t, " done cycle"}, dn_cyc, v.dn_cyc);
    checkOutput({t, " done count"}, dn_cnt, v.dn_cnt);
    checkOutput({t, " div_zero cycle"}, dz_cyc, v.dz_cyc);
    checkOutput({t, " div_zero count"}, dz_cnt, v.dz_cnt);
    checkOutput({t, " busy cycles"}, busy_cnt, v.busy_cnt);
    checkOutput({t, " busy last"}, busy_last, v.busy_last);
    checkOutput({t, " eng_sel"}, int'(sel1), int'(v.eng_sel));
    checkOutput({t, " eng_sel last"}, int'(sel_last), int'(v.eng_sel));
    checkOutput({t, " sel_mux_hi"}, int'(hi1), int'(v.sel));
    checkOutput({t, " sel_mux_lo"}, int'(lo1), int'(v.sel));
    checkOutput({t, " exclusive pulses"}, excl, 0);
  endtask

  task automatic checkResetOutputs(input string t);
    checkOutput({t, " busy"}, int'(busy), 0);
    checkOutput({t, " done"}, int'(done), 0);
    checkOutput({t, " div_zero"}, int'(div_zero), 0);
    checkOutput({t, " eng_start"}, int'(eng_start), 0);
    checkOutput({t, " HiLo_load"}, int'(HiLo_load), 0);
    checkOutput({t, " eng_sel"}, int'(eng_sel), 0);
    checkOutput({t, " sel_mux_hi"}, int'(sel_mux_hi), 1);
    checkOutput({t, " sel_mux_lo"}, int'(sel_mux_lo), 1);
  endtask

  task automatic waitIdle(input string t);
    int n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    checkOutput({t, " returns idle"}, int'(busy), 0);
  endtask

  vec_t vecs[7];

  initial begin
    // op, b, abort_cyc, start2_cyc, eng_start, HiLo, done, div_zero, busy cycles, eng_sel
    vecs[0] = mk(1'b0, 32'd5, -1, -1, 1, 33, 34, 0, 34, 1'b0);
    vecs[1] = mk(1'b1, 32'd7, -1, -1, 1, 33, 34, 0, 34, 1'b1);
    vecs[2] = mk(1'b1, 32'd0, -1, -1, 0,  0,  0, 1,  1, 1'b1);
    vecs[3] = mk(1'b0, 32'd5, 10, -1, 1,  0,  0, 0, 10, 1'b0);
    vecs[4] = mk(1'b0, 32'd5, 33,  5, 1,  0,  0, 0, 33, 1'b0);
    vecs[5] = mk(1'b0, 32'd5,  0, -1, 0,  0,  0, 0,  0, 1'b0);
    vecs[6] = mk(1'b1, 32'd0,  1, -1, 0,  0,  0, 0,  1, 1'b1);

    reset = 1'b0; start = 1'b0; op = 1'b0; operand_b = 32'd0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");

    // First start presented together with reset release.
    reset = 1'b1; start = 1'b1; op = 1'b0; operand_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("first start eng_start", int'(eng_start), 1);
    checkOutput("first start busy", int'(busy), 1);
    waitIdle("first start");

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    // Abort at cycle 10, new start at cycle 11 is accepted.
    op = 1'b0; operand_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; es_cyc = 0; hl_cyc = 0; busy_last = -1;
    for (int k = 1; k <= 50; k++) begin
      abort = (k == 10);
      start = (k == 11);
      #1;
      if (k == 11) busy_last = int'(busy);
      if (eng_start && k > 1 && es_cyc == 0) es_cyc = k;
      if (HiLo_load && hl_cyc == 0) hl_cyc = k;
      @(posedge clk); #1;
    end
    abort = 1'b0; start = 1'b0;
    checkOutput("restart busy@11", busy_last, 0);
    checkOutput("restart eng_start", es_cyc, 12);
    checkOutput("restart HiLo_load", hl_cyc, 44);

    // Start accepted in the IDLE cycle right after DONE.
    op = 1'b1; operand_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dn_cyc = 0; es_cyc = 0; sel1 = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      start = (k == 35);
      if (start) op = 1'b0;
      #1;
      if (done && dn_cyc == 0) dn_cyc = k;
      if (eng_start && k > 1 && es_cyc == 0) begin es_cyc = k; sel1 = eng_sel; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("b2b done", dn_cyc, 34);
    checkOutput("b2b eng_start", es_cyc, 36);
    checkOutput("b2b eng_sel", int'(sel1), 0);
    waitIdle("b2b");

    // Reset asserted at cycle 20 of a div.
    op = 1'b1; operand_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    #2;
    checkOutput("pre-reset eng_sel", int'(eng_sel), 1);
    reset = 1'b0;
    #1;
    checkResetOutputs("mid reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    hl_cnt = 0; dn_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < WIN; k++) begin
      if (HiLo_load) hl_cnt++;
      if (done) dn_cnt++;
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
    checkOutput("post reset HiLo_load", hl_cnt, 0);
    checkOutput("post reset done", dn_cnt, 0);
    checkOutput("post reset busy", busy_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 32: mult engine latency in cycles (legal 1..64).
REQ-002 SHALL have parameter DIV_CYCLES, default 32: div engine latency in cycles (legal 1..64).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  request from control_unit; sampled only in IDLE.
REQ-006 SHALL have port op  in  1  operation: 0 = mult, 1 = div.
REQ-007 SHALL have port operand_b  in  32  B register value, used for the divide-by-zero check.
REQ-008 SHALL have port abort  in  1  flush request; cancels any operation in progress.
REQ-009 SHALL have port busy  out  1  high in every non-IDLE state.
REQ-010 SHALL have port done  out  1  one-cycle pulse on normal completion.
REQ-011 SHALL have port div_zero  out  1  one-cycle pulse on a div with operand_b == 0.
REQ-012 SHALL have port eng_start  out  1  one-cycle start pulse to the selected engine.
REQ-013 SHALL have port eng_sel  out  1  engine select: 0 = mult, 1 = div.
REQ-014 SHALL have port HiLo_load  out  1  write enable for the Hi and Lo registers.
REQ-015 SHALL have ports sel_mux_hi and sel_mux_lo  out  1 each  Hi/Lo source select: 0 = DIV output, 1 = MULT output.

Function
REQ-016 SHALL implement states IDLE, RUN, WRITE, DONE and EXC.
REQ-017 SHALL latch op at the edge where start is sampled in IDLE.
- eng_sel, sel_mux_hi and sel_mux_lo SHALL derive only from the latched op.
- sel_mux_hi = sel_mux_lo = ~latched op.
REQ-018 IDLE, start=1, and not (op=1 and operand_b==0): next state RUN.
- Counter loads N-1, where N = MULT_CYCLES or DIV_CYCLES per op.
REQ-019 IDLE, start=1, op=1, operand_b==0: next state EXC.
- No eng_start, no HiLo_load.
REQ-020 eng_start SHALL be high only in the first RUN cycle.
REQ-021 RUN SHALL decrement the counter each cycle; when counter==0, next state is WRITE.
- RUN lasts exactly N cycles.
REQ-022 WRITE SHALL assert HiLo_load for exactly one cycle, gated by ~abort; next state DONE.
REQ-023 DONE SHALL assert done for one cycle; next state IDLE.
REQ-024 EXC SHALL assert div_zero for one cycle; next state IDLE.
REQ-025 Cycle-level latency, start sampled at edge 0:
- RUN cycles 1..N, WRITE cycle N+1, DONE cycle N+2, IDLE from cycle N+3.
- busy high in cycles 1..N+2.
REQ-026 start while busy SHALL be ignored, with no queuing.
- A new start is accepted in the IDLE cycle directly after DONE or EXC.
REQ-027 abort=1 in any non-IDLE state: next state IDLE.
- done, div_zero and HiLo_load SHALL NOT assert in the abort cycle or afterwards for that operation.
REQ-028 abort=1 and start=1 together in IDLE: abort wins and no operation starts.
REQ-029 Counter width SHALL be 6 bits and SHALL NOT wrap; it is reloaded only on entry to RUN.
REQ-030 done, div_zero, HiLo_load and eng_start SHALL be mutually exclusive in every cycle.

Reset
REQ-031 reset low SHALL immediately force state IDLE, counter 0 and latched op 0, independent of clk.
REQ-032 Output values during reset:
- busy, done, div_zero, eng_start and HiLo_load SHALL be 0.
- eng_sel SHALL be 0; sel_mux_hi and sel_mux_lo SHALL be 1.
REQ-033 Reset asserted mid-operation SHALL discard the operation, with no HiLo_load and no done.
REQ-034 The first start SHALL be accepted on the first rising edge after reset deassertion.

Structure
REQ-035 Package muldiv_pkg SHALL hold the state encoding and OP_MULT=0 / OP_DIV=1.
- It SHALL also hold the mux select constants SEL_DIV=0 / SEL_MULT=1.
REQ-036 The cycle down-counter SHALL be one sub-module, muldiv_cnt.
- Ports: load, load value, decrement enable, zero flag.
- The FSM and output decode SHALL stay in muldiv_sequencer.

Verification
REQ-037 mult, MULT_CYCLES=32, start pulse at cycle 0 ->
- eng_start @1, HiLo_load @33, done @34, sel_mux_hi=1, busy high in cycles 1..34.
REQ-038 div, operand_b=7, DIV_CYCLES=32 ->
- eng_sel=1, HiLo_load @33 with sel_mux_hi=sel_mux_lo=0, done @34.
REQ-039 div, operand_b=0 ->
- div_zero @1 only, no eng_start/HiLo_load/done, busy high only in cycle 1, IDLE @2.
REQ-040 mult start, then abort at cycle 10 ->
- IDLE @11, no HiLo_load and no done; a new start at cycle 11 is accepted.
REQ-041 second start at cycle 5 of a mult, and abort asserted during WRITE ->
- second start ignored; HiLo_load suppressed in WRITE; done not asserted.
REQ-042 reset low at cycle 20 of a div ->
- all outputs immediately at reset values; no HiLo_load; IDLE after release.
